// File: rtl/rv32i_types_pkg.sv
// Shared types for the out-of-order writeback path: unit ids, the buffered
// result payload and the default port counts.
package rv32i_types_pkg;

    localparam int unsigned NUM_FU_UNITS = 5;
    localparam int unsigned NUM_WB_PORTS = 2;
    localparam int unsigned CB_INDEX_W   = 4;
    localparam int unsigned UNIT_ID_W    = 3;

    typedef enum logic [UNIT_ID_W-1:0] {
        FU_ARITH,
        FU_MULT,
        FU_DIV,
        FU_LS,
        FU_VEC
    } fu_id_t;

    typedef struct packed {
        logic [CB_INDEX_W-1:0] index;
        logic [4:0]            rd;
        logic [31:0]           wdata;
        logic                  wen;
        logic                  exception;
    } wb_result_t;

    // Register write only happens for non-excepting results targeting a real register.
    function automatic logic wb_wen_qual(input wb_result_t r);
        return r.wen && !r.exception && (r.rd != '0);
    endfunction

endpackage

// File: rtl/ooo_rr_picker.sv
// Combinational k-of-n round-robin selector: scans requests from start_i,
// wrapping, and hands the first NUM_PORTS requesters to ports in scan order.
module ooo_rr_picker
    import rv32i_types_pkg::*;
#(
    parameter int unsigned NUM_REQ   = NUM_FU_UNITS,
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [UNIT_ID_W-1:0]                start_i,
    output logic [NUM_REQ-1:0]                  grant_o,
    output logic [NUM_PORTS-1:0][UNIT_ID_W-1:0] port_id_o,
    output logic [NUM_PORTS-1:0]                port_valid_o,
    output logic [UNIT_ID_W-1:0]                last_id_o
);

    int unsigned u;
    int unsigned cnt;

    always_comb begin
        grant_o      = '0;
        port_id_o    = '0;
        port_valid_o = '0;
        last_id_o    = '0;
        u            = 0;
        cnt          = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            u = 32'(start_i) + i;
            if (u >= NUM_REQ) begin
                u = u - NUM_REQ;
            end
            if (req_i[u] && (cnt < NUM_PORTS)) begin
                grant_o[u]          = 1'b1;
                port_id_o[cnt]      = UNIT_ID_W'(u);
                port_valid_o[cnt]   = 1'b1;
                last_id_o           = UNIT_ID_W'(u);
                cnt                 = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/ooo_completion_arbiter.sv
// Buffers one finished result per functional unit and drains up to
// NUM_WB_PORTS of them per cycle, round-robin, onto registered writeback ports.
module ooo_completion_arbiter
    import rv32i_types_pkg::*;
#(
    parameter int unsigned NUM_UNITS    = rv32i_types_pkg::NUM_FU_UNITS,
    parameter int unsigned NUM_WB_PORTS = rv32i_types_pkg::NUM_WB_PORTS,
    parameter int unsigned INDEX_W      = rv32i_types_pkg::CB_INDEX_W
) (
    input  logic                                   CLK,
    input  logic                                   nRST,
    input  logic                                   flush,
    input  logic [NUM_UNITS-1:0]                   done_i,
    input  logic [NUM_UNITS-1:0][INDEX_W-1:0]      index_i,
    input  logic [NUM_UNITS-1:0][4:0]              rd_i,
    input  logic [NUM_UNITS-1:0][31:0]             wdata_i,
    input  logic [NUM_UNITS-1:0]                   wen_i,
    input  logic [NUM_UNITS-1:0]                   exception_i,
    output logic [NUM_UNITS-1:0]                   stall_o,
    output logic [NUM_WB_PORTS-1:0]                wb_valid_o,
    output logic [NUM_WB_PORTS-1:0][INDEX_W-1:0]   wb_index_o,
    output logic [NUM_WB_PORTS-1:0][4:0]           wb_rd_o,
    output logic [NUM_WB_PORTS-1:0][31:0]          wb_wdata_o,
    output logic [NUM_WB_PORTS-1:0]                wb_wen_o,
    output logic [NUM_WB_PORTS-1:0]                wb_exception_o,
    output logic [NUM_WB_PORTS-1:0][UNIT_ID_W-1:0] wb_unit_o
);

    logic [NUM_UNITS-1:0]                   pending_q;
    wb_result_t                             slot_q [NUM_UNITS];
    wb_result_t                             in_res [NUM_UNITS];
    logic [UNIT_ID_W-1:0]                   rr_ptr_q;
    logic [NUM_UNITS-1:0]                   grant;
    logic [NUM_UNITS-1:0]                   accept;
    logic [NUM_WB_PORTS-1:0][UNIT_ID_W-1:0] port_id;
    logic [NUM_WB_PORTS-1:0]                port_valid;
    logic [UNIT_ID_W-1:0]                   last_id;
    wb_result_t                             sel;

    logic [NUM_WB_PORTS-1:0]                wb_valid_q, wb_valid_d;
    logic [NUM_WB_PORTS-1:0][INDEX_W-1:0]   wb_index_q, wb_index_d;
    logic [NUM_WB_PORTS-1:0][4:0]           wb_rd_q, wb_rd_d;
    logic [NUM_WB_PORTS-1:0][31:0]          wb_wdata_q, wb_wdata_d;
    logic [NUM_WB_PORTS-1:0]                wb_wen_q, wb_wen_d;
    logic [NUM_WB_PORTS-1:0]                wb_exception_q, wb_exception_d;
    logic [NUM_WB_PORTS-1:0][UNIT_ID_W-1:0] wb_unit_q, wb_unit_d;

    ooo_rr_picker #(
        .NUM_REQ   (NUM_UNITS),
        .NUM_PORTS (NUM_WB_PORTS)
    ) u_picker (
        .req_i        (pending_q),
        .start_i      (rr_ptr_q),
        .grant_o      (grant),
        .port_id_o    (port_id),
        .port_valid_o (port_valid),
        .last_id_o    (last_id)
    );

    // A granted slot drains this edge, so it is free to take a new result at once.
    always_comb begin
        stall_o = flush ? '0 : (pending_q & ~grant);
        accept  = flush ? '0 : (done_i & ~stall_o);
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            in_res[u] = '{index: index_i[u], rd: rd_i[u], wdata: wdata_i[u],
                          wen: wen_i[u], exception: exception_i[u]};
        end
    end

    always_comb begin
        wb_valid_d     = '0;
        wb_index_d     = '0;
        wb_rd_d        = '0;
        wb_wdata_d     = '0;
        wb_wen_d       = '0;
        wb_exception_d = '0;
        wb_unit_d      = '0;
        sel            = '0;
        for (int unsigned p = 0; p < NUM_WB_PORTS; p++) begin
            if (port_valid[p]) begin
                sel               = slot_q[port_id[p]];
                wb_valid_d[p]     = 1'b1;
                wb_index_d[p]     = sel.index;
                wb_rd_d[p]        = sel.rd;
                wb_wdata_d[p]     = sel.wdata;
                wb_wen_d[p]       = wb_wen_qual(sel);
                wb_exception_d[p] = sel.exception;
                wb_unit_d[p]      = port_id[p];
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            if (accept[u]) begin
                slot_q[u] <= in_res[u];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST || flush) begin
            pending_q      <= '0;
            rr_ptr_q       <= '0;
            wb_valid_q     <= '0;
            wb_index_q     <= '0;
            wb_rd_q        <= '0;
            wb_wdata_q     <= '0;
            wb_wen_q       <= '0;
            wb_exception_q <= '0;
            wb_unit_q      <= '0;
        end else begin
            pending_q      <= accept | (pending_q & ~grant);
            wb_valid_q     <= wb_valid_d;
            wb_index_q     <= wb_index_d;
            wb_rd_q        <= wb_rd_d;
            wb_wdata_q     <= wb_wdata_d;
            wb_wen_q       <= wb_wen_d;
            wb_exception_q <= wb_exception_d;
            wb_unit_q      <= wb_unit_d;
            if (|grant) begin
                rr_ptr_q <= (last_id == UNIT_ID_W'(NUM_UNITS - 1)) ? '0 : last_id + 1'b1;
            end
        end
    end

    assign wb_valid_o     = wb_valid_q;
    assign wb_index_o     = wb_index_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_wdata_o     = wb_wdata_q;
    assign wb_wen_o       = wb_wen_q;
    assign wb_exception_o = wb_exception_q;
    assign wb_unit_o      = wb_unit_q;

endmodule

// File: doc/ooo_completion_arbiter.md
Name: ooo_completion_arbiter

Overview:
Shares a limited number of completion-buffer writeback ports among the out-of-order functional units (arith, mult, div, load/store, vector). Each unit presents a finished result (done, CB index, rd, wdata, wen, exception). The block buffers one result per unit, picks up to NUM_WB_PORTS results per cycle in round-robin order, and drives registered writeback ports into the completion buffer. Units receive a per-unit stall when their holding slot cannot drain.

Parameters:
NUM_UNITS, 5, number of requesting functional units (0=arith, 1=mult, 2=div, 3=ls, 4=vector)
NUM_WB_PORTS, 2, completion-buffer write ports driven per cycle (1..NUM_UNITS)
INDEX_W, 4, completion-buffer index width ($clog2(NUM_CB_ENTRY))

Ports:
CLK  in  1  clock
nRST  in  1  synchronous active-low reset
flush  in  1  mispredict/exception flush; drop all in-flight results
done_i  in  NUM_UNITS  unit result valid
index_i  in  NUM_UNITS x INDEX_W  CB index per unit
rd_i  in  NUM_UNITS x 5  destination register per unit
wdata_i  in  NUM_UNITS x 32  result data per unit
wen_i  in  NUM_UNITS  register write enable per unit
exception_i  in  NUM_UNITS  exception flag per unit
stall_o  out  NUM_UNITS  unit must hold its result this cycle
wb_valid_o  out  NUM_WB_PORTS  writeback port valid
wb_index_o  out  NUM_WB_PORTS x INDEX_W  CB index
wb_rd_o  out  NUM_WB_PORTS x 5  destination register
wb_wdata_o  out  NUM_WB_PORTS x 32  data
wb_wen_o  out  NUM_WB_PORTS  register write enable (qualified)
wb_exception_o  out  NUM_WB_PORTS  exception flag
wb_unit_o  out  NUM_WB_PORTS x 3  source unit id

Behaviour:
- Reset (nRST=0 at CLK edge): all pending bits, wb_* outputs and rr_ptr cleared to 0. stall_o is therefore 0 in the cycle after reset.
- Per-unit holding slot: pending[u] plus a wb_result_t payload.
- Accept: capture done_i[u] && !stall_o[u] into the slot at the edge. The unit must hold done_i and its payload stable while stall_o[u]=1.
- Grant (combinational from pending): scan units starting at rr_ptr, wrapping modulo NUM_UNITS. The first NUM_WB_PORTS pending units win. The k-th winner goes to port k.
- stall_o[u] = pending[u] && !grant[u]. A granted slot can accept a new result in the same cycle, giving 1 result/cycle/unit sustained throughput.
- Outputs are registered. A granted slot's payload appears on wb_* at the next edge. Latency from done_i to wb_valid_o is 2 edges when uncontested.
- Unused ports have wb_valid_o=0; their other fields are don't-care but held at 0.
- wb_wen_o = wen && !exception && (rd != 0).
- rr_ptr update: if any grant occurred, rr_ptr <= (index of last granted unit + 1) mod NUM_UNITS; otherwise it holds. No unit waits more than ceil(NUM_UNITS/NUM_WB_PORTS) grant cycles.
- flush (synchronous, priority below reset):
  - At the edge, clear all pending bits and wb_valid_o, and set rr_ptr to 0.
  - done_i is ignored in the flush cycle (nothing is captured) and stall_o is forced 0.
  - The cycle after flush behaves as post-reset.
- Simultaneous accept and grant on the same unit: grant drains the old payload to the outputs, and the slot loads the new payload. No loss, no duplication.
- Reset or flush mid-operation: any result held in a slot is discarded and never appears on wb_*.
- NUM_WB_PORTS >= NUM_UNITS degenerates to a pure register stage: stall_o is always 0.

Decomposition:
- Shared package (rv32i_types_pkg):
  - wb_result_t struct {index, rd, wdata, wen, exception}
  - constants NUM_FU_UNITS=5, NUM_WB_PORTS=2
  - unit-id enum fu_id_t {FU_ARITH, FU_MULT, FU_DIV, FU_LS, FU_VEC}
- Sub-module ooo_rr_picker: purely combinational k-of-n round-robin selector. Inputs are request vector and start pointer; outputs are grant vector, per-port unit ids, per-port valid, and last-granted id. The top level holds the slots, the pointer and the output registers.

Test Plan:
- Reset then a single arith result (done_i[0]=1, index 3, rd 5, wdata 0xDEADBEEF) -> two edges later port0 valid with index 3, rd 5, wdata 0xDEADBEEF, wb_wen_o=1, unit 0; port1 invalid; stall_o=0 throughout.
- All five units done in the same cycle, rr_ptr=0 -> grants over consecutive cycles are {0,1}, {2,3}, {4}. stall_o goes 11100, then 10000, then 00000. rr_ptr ends at 0.
- Mult issues back-to-back results every cycle for 8 cycles, other units idle -> 8 consecutive port0 writebacks in order, stall_o[1] never asserted.
- Flush asserted while units 2 and 3 are pending and done_i[4]=1 -> no wb_valid_o after the flush edge, all stall_o=0, unit 4's result is not captured, rr_ptr=0.
- Exception result from ls (exception_i[3]=1, wen_i=1, rd 7) -> wb_exception_o=1, wb_wen_o=0. A separate case with rd=0 and wen_i=1 -> wb_wen_o=0.
- Fairness: units 0 and 1 done every cycle, units 2 and 4 also done every cycle -> over 10 cycles each unit gets at least 3 grants, and no stall lasts longer than 3 cycles.
